regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default core_cfg.REG_ADDR_WIDTH, register index width (2**ADDR_WIDTH entries).
REQ-002 SHALL have parameter DATA_WIDTH, default core_cfg.XLEN, register width.
REQ-003 SHALL have parameter NUM_RD, default 2, read port count (1..6).
REQ-004 SHALL have parameter NUM_WR, default 2, write port count (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and is never written or marked pending.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 ren  in  NUM_RD  per-port read enable.
REQ-010 raddr  in  NUM_RD x ADDR_WIDTH  read indices.
REQ-011 rdata  out  NUM_RD x DATA_WIDTH  registered read data.
REQ-012 rbusy  out  NUM_RD  registered pending flag of the entry read.
REQ-013 wen  in  NUM_WR  per-port write enable.
REQ-014 waddr  in  NUM_WR x ADDR_WIDTH  write indices.
REQ-015 wdata  in  NUM_WR x DATA_WIDTH  write data.
REQ-016 alloc_en  in  1  marks alloc_addr pending (new in-flight producer).
REQ-017 alloc_addr  in  ADDR_WIDTH  entry to mark pending.
REQ-018 flush  in  1  clears all pending bits.

Function
REQ-019 Read latency SHALL be 1 cycle: with ren[i]=1 at edge N, rdata[i]/rbusy[i] are valid after edge N.
REQ-020 With ren[i]=0, rdata[i] and rbusy[i] SHALL hold their previous values.
REQ-021 With ZERO_REG=1 and raddr[i]=0, rdata[i] SHALL load 0 and rbusy[i] SHALL load 0.
REQ-022 Write-first bypass: if wen[j]=1 and waddr[j]=raddr[i] (excluding entry 0 under ZERO_REG) in the same cycle, rdata[i] SHALL load wdata[j].
REQ-023 When several write ports target one entry in a cycle, the highest-index port SHALL win, for both the array update and the bypass.
REQ-024 Writes to entry 0 with ZERO_REG=1 SHALL be discarded.
REQ-025 Each entry SHALL carry a pending bit: cleared by any enabled write to that entry and set by alloc_en at alloc_addr.
REQ-026 Simultaneous write and alloc to the same entry SHALL leave it pending (alloc wins).
REQ-027 flush SHALL clear every pending bit, with priority over alloc_en in the same cycle.
REQ-028 rbusy[i] SHALL load the post-update pending value of raddr[i], after that cycle's writes, alloc and flush are applied.
REQ-029 alloc_en to entry 0 with ZERO_REG=1 SHALL be ignored.
REQ-030 Same-cycle read and write of the same entry with ren=0 SHALL still commit the write.

Reset
REQ-031 rst=1 SHALL immediately force, without waiting for a clock edge, all array entries, all pending bits, every rdata to 0, and every rbusy to 0.
REQ-032 Reads, writes and allocs coincident with rst=1 SHALL have no effect.
REQ-033 The first edge after rst deasserts SHALL operate normally.

Structure
REQ-034 NUM_RD_PORTS and NUM_WR_PORTS defaults SHALL be added to core_cfg in config_pkg and used as parameter defaults.
REQ-035 The pending-bit logic SHALL live in one sub-module, regfile_scoreboard (inputs: write clears, alloc, flush; outputs: next-pending lookup per read port).
REQ-036 Write-port priority resolution SHALL be a single shared loop, reused by the array update and the bypass.

Verification
REQ-037 Reset then read entries 1..31 on all ports -> rdata=0, rbusy=0.
REQ-038 Same cycle: wen0 x5=0xAAAA and wen1 x5=0x5555, ren0 raddr=5 -> rdata0=0x5555; next read of x5 = 0x5555.
REQ-039 alloc x7; next cycle ren raddr=7 -> rbusy=1; then write x7=0x12 while reading x7 -> rdata=0x12, rbusy=0.
REQ-040 Same cycle alloc x3 and write x3=0x9, read x3 -> rdata=0x9, rbusy=1; flush plus alloc x3 -> next read rbusy=0.
REQ-041 Write x0=0xFFFF and alloc x0, read x0 on all ports -> rdata=0, rbusy=0.
REQ-042 Assert rst mid-stream, between edges, after writing x9=0x33 -> rdata drops to 0 without a clock edge; post-reset read of x9 = 0.

Source files
------------

// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Core-wide configuration shared by the register file and its neighbours.
// core_cfg holds the default geometry of the integer register file:
//   REG_ADDR_WIDTH - register index width (2**REG_ADDR_WIDTH entries)
//   XLEN           - register width in bits
//   NUM_RD_PORTS   - default number of register-file read ports
//   NUM_WR_PORTS   - default number of register-file write ports
// ---------------------------------------------------------------------------
package config_pkg;

  typedef struct packed {
    int REG_ADDR_WIDTH;
    int XLEN;
    int NUM_RD_PORTS;
    int NUM_WR_PORTS;
  } core_cfg_t;

  localparam core_cfg_t core_cfg = '{
    REG_ADDR_WIDTH: 5,
    XLEN:           32,
    NUM_RD_PORTS:   2,
    NUM_WR_PORTS:   2
  };

endpackage : config_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One pending bit per register-file entry, marking entries whose producer is
// still in flight. Per cycle the next pending vector is formed as:
//   write clear -> alloc set (alloc beats a same-cycle write) -> flush clear
// and the post-update value is looked up for every read port so the top can
// register it alongside the read data.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_clr_i        per-entry clear from the resolved write ports
//   alloc_en_i      mark alloc_addr_i pending
//   alloc_addr_i    entry to mark pending
//   flush_i         clear every pending bit (beats alloc)
//   raddr_i         read-port indices
//   pend_next_o     post-update pending bit of each read port's entry
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import config_pkg::*;
#(
  parameter int ADDR_WIDTH  = core_cfg.REG_ADDR_WIDTH,
  parameter int NUM_RD      = core_cfg.NUM_RD_PORTS,
  parameter int ZERO_REG    = 1,
  localparam int NUM_ENTRIES = 1 << ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ENTRIES-1:0]              wr_clr_i,
  input  logic                                alloc_en_i,
  input  logic [ADDR_WIDTH-1:0]               alloc_addr_i,
  input  logic                                flush_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_RD-1:0]                   pend_next_o
);

  logic [NUM_ENTRIES-1:0] pend_q;
  logic [NUM_ENTRIES-1:0] pend_d;
  logic                   alloc_ok;

  // Entry 0 is hard-wired when ZERO_REG is set, so it never becomes pending.
  assign alloc_ok = alloc_en_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    pend_d = pend_q;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (wr_clr_i[e]) pend_d[e] = 1'b0;
    end
    if (alloc_ok) pend_d[alloc_addr_i] = 1'b1;
    if (flush_i)  pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    pend_next_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      pend_next_o[i] = pend_d[raddr_i[i]];
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-ported register file with registered reads, write-first bypass and a
// per-entry pending (scoreboard) bit.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset (clears everything)
//   ren          per-read-port enable; a disabled port holds its outputs
//   raddr        read indices
//   rdata        registered read data (1-cycle latency, sees same-cycle writes)
//   rbusy        registered post-update pending bit of the entry read
//   wen          per-write-port enable
//   waddr        write indices
//   wdata        write data; highest-index port wins on address collisions
//   alloc_en     mark alloc_addr pending
//   alloc_addr   entry to mark pending
//   flush        clear all pending bits
// ---------------------------------------------------------------------------
module regfile_mp
  import config_pkg::*;
#(
  parameter int ADDR_WIDTH = core_cfg.REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = core_cfg.XLEN,
  parameter int NUM_RD     = core_cfg.NUM_RD_PORTS,
  parameter int NUM_WR     = core_cfg.NUM_WR_PORTS,
  parameter int ZERO_REG   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RD-1:0]                   ren,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]                   rbusy,
  input  logic [NUM_WR-1:0]                   wen,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wdata,
  input  logic                                alloc_en,
  input  logic [ADDR_WIDTH-1:0]               alloc_addr,
  input  logic                                flush
);

  localparam int NUM_ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]              mem_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]              mem_d [NUM_ENTRIES];

  // Per-entry resolved write: hit flag and winning data.
  logic [NUM_ENTRIES-1:0]             wr_hit;
  logic [DATA_WIDTH-1:0]              wr_val [NUM_ENTRIES];

  logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_RD-1:0]                  rbusy_q, rbusy_d;
  logic [NUM_RD-1:0]                  pend_next;

  // Write-port priority resolution. Ports are scanned in ascending order so
  // a later (higher-index) port overwrites an earlier one on the same entry.
  // Both the array update and the read bypass consume this single result.
  always_comb begin
    wr_hit = '0;
    wr_val = '{default: '0};
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j]) begin
        wr_hit[waddr[j]] = 1'b1;
        wr_val[waddr[j]] = wdata[j];
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0] = 1'b0;
      wr_val[0] = '0;
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      mem_d[e] = wr_hit[e] ? wr_val[e] : mem_q[e];
    end
  end

  // NOTE: the array is reset like ordinary flops because reset must clear
  // every entry immediately; this costs a reset net per bit but is required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .wr_clr_i     (wr_hit),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .flush_i      (flush),
    .raddr_i      (raddr),
    .pend_next_o  (pend_next)
  );

  // Reading mem_d rather than mem_q gives the write-first bypass for free.
  always_comb begin
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ren[i]) begin
        if ((ZERO_REG != 0) && (raddr[i] == '0)) begin
          rdata_d[i] = '0;
          rbusy_d[i] = 1'b0;
        end else begin
          rdata_d[i] = mem_d[raddr[i]];
          rbusy_d[i] = pend_next[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp with default geometry (32 x 32, 2R/2W,
// ZERO_REG=1). Directed vectors come from a table; expected read results are
// queued when a cycle is driven and compared after the following edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          ren;
  logic [1:0][AW-1:0]  raddr;
  logic [1:0][DW-1:0]  rdata;
  logic [1:0]          rbusy;
  logic [1:0]          wen;
  logic [1:0][AW-1:0]  waddr;
  logic [1:0][DW-1:0]  wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (2),
    .NUM_WR     (2),
    .ZERO_REG   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

  typedef struct {
    string              name;
    logic [1:0]         ren;
    logic [1:0][AW-1:0] ra;
    logic [1:0]         wen;
    logic [1:0][AW-1:0] wa;
    logic [1:0][DW-1:0] wd;
    logic               al;
    logic [AW-1:0]      aa;
    logic               fl;
    logic [1:0][DW-1:0] ed;
    logic [1:0]         eb;
  } vec_t;

  typedef struct {
    string              name;
    logic [1:0][DW-1:0] d;
    logic [1:0]         b;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state for the random phase.
  logic [DW-1:0] mem_m [32];
  logic [31:0]   pend_m;
  exp_t          last_m;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string n, input logic [1:0] r,
      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
      input logic [1:0] w,
      input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
      input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
      input logic al, input logic [AW-1:0] aa, input logic fl,
      input logic [DW-1:0] ed0, input logic eb0,
      input logic [DW-1:0] ed1, input logic eb1);
    vec_t v;
    v.name = n;  v.ren = r;   v.ra = {ra1, ra0};
    v.wen  = w;  v.wa  = {wa1, wa0}; v.wd = {wd1, wd0};
    v.al   = al; v.aa  = aa;  v.fl = fl;
    v.ed   = {ed1, ed0};      v.eb = {eb1, eb0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ren = v.ren; raddr = v.ra; wen = v.wen; waddr = v.wa; wdata = v.wd;
    alloc_en = v.al; alloc_addr = v.aa; flush = v.fl;
  endtask

  task automatic cycle_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s_rdata%0d", e.name, i), rdata[i], e.d[i]);
        check($sformatf("%s_rbusy%0d", e.name, i), {31'b0, rbusy[i]},
              {31'b0, e.b[i]});
      end
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.name = v.name; e.d = v.ed; e.b = v.eb;
    sb_q.push_back(e);
    cycle_check();
  endtask

  // Sequential-semantics model: write ports in order, then alloc, then flush.
  task automatic model_step(input vec_t v, output exp_t e);
    logic [DW-1:0] nm [32];
    logic [31:0]   np;
    nm = mem_m;
    np = pend_m;
    for (int j = 0; j < 2; j++) begin
      if (v.wen[j] && v.wa[j] != 0) begin
        nm[v.wa[j]] = v.wd[j];
        np[v.wa[j]] = 1'b0;
      end
    end
    if (v.al && v.aa != 0) np[v.aa] = 1'b1;
    if (v.fl) np = '0;
    e = last_m;
    e.name = v.name;
    for (int i = 0; i < 2; i++) begin
      if (v.ren[i]) begin
        e.d[i] = (v.ra[i] == 0) ? '0 : nm[v.ra[i]];
        e.b[i] = (v.ra[i] == 0) ? 1'b0 : np[v.ra[i]];
      end
    end
    mem_m  = nm;
    pend_m = np;
    last_m = e;
  endtask

  initial begin
    vec_t vecs[16];
    vec_t v;
    exp_t e;

    ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    rst = 1'b1;
    #3;
    check("reset_rdata0", rdata[0], '0);
    check("reset_rdata1", rdata[1], '0);
    check("reset_rbusy", {30'b0, rbusy}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Every entry reads back zero and idle after reset.
    for (int a = 1; a < 32; a++) begin
      apply(mkv($sformatf("post_reset_x%0d", a), 2'b11, AW'(a), AW'(a),
                2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    //               name               ren   ra0 ra1 wen   wa0 wd0       wa1 wd1       al aa fl  ed0       eb0 ed1       eb1
    vecs[0]  = mkv("wr_prio_bypass",   2'b01, 5,  0, 2'b11, 5, 'hAAAA,   5, 'h5555,    0, 0, 0, 'h5555,   0, 0,        0);
    vecs[1]  = mkv("rd_x5_both",       2'b11, 5,  5, 2'b00, 0, 0,        0, 0,         0, 0, 0, 'h5555,   0, 'h5555,   0);
    vecs[2]  = mkv("alloc_x7_hold",    2'b00, 0,  0, 2'b00, 0, 0,        0, 0,         1, 7, 0, 'h5555,   0, 'h5555,   0);
    vecs[3]  = mkv("rd_x7_busy",       2'b01, 7,  0, 2'b00, 0, 0,        0, 0,         0, 0, 0, 0,        1, 'h5555,   0);
    vecs[4]  = mkv("wr_x7_bypass",     2'b11, 7,  7, 2'b01, 7, 'h12,     0, 0,         0, 0, 0, 'h12,     0, 'h12,     0);
    vecs[5]  = mkv("alloc_wr_x3",      2'b01, 3,  0, 2'b10, 0, 0,        3, 'h9,       1, 3, 0, 'h9,      1, 'h12,     0);
    vecs[6]  = mkv("flush_alloc_x3",   2'b10, 0,  3, 2'b00, 0, 0,        0, 0,         1, 3, 1, 'h9,      1, 'h9,      0);
    vecs[7]  = mkv("rd_x3_idle",       2'b01, 3,  0, 2'b00, 0, 0,        0, 0,         0, 0, 0, 'h9,      0, 'h9,      0);
    vecs[8]  = mkv("x0_wr_alloc",      2'b11, 0,  0, 2'b11, 0, 'hFFFF,   0, 'hFFFF,    1, 0, 0, 0,        0, 0,        0);
    vecs[9]  = mkv("rd_x0",            2'b11, 0,  0, 2'b00, 0, 0,        0, 0,         0, 0, 0, 0,        0, 0,        0);
    vecs[10] = mkv("wr_no_ren",        2'b00, 10, 10, 2'b01, 10, 'hBEEF, 0, 0,         0, 0, 0, 0,        0, 0,        0);
    vecs[11] = mkv("rd_x10",           2'b01, 10, 0, 2'b00, 0, 0,        0, 0,         0, 0, 0, 'hBEEF,   0, 0,        0);
    vecs[12] = mkv("wr_alloc_x11_p1",  2'b10, 0,  11, 2'b10, 0, 0,       11, 'h77,     1, 11, 0, 'hBEEF,  0, 'h77,     1);
    vecs[13] = mkv("wr_clear_x11",     2'b10, 0,  11, 2'b01, 11, 'h88,   0, 0,         0, 0, 0, 'hBEEF,   0, 'h88,     0);
    vecs[14] = mkv("wr_two_entries",   2'b11, 12, 13, 2'b11, 12, 'h1,    13, 'h2,      0, 0, 0, 'h1,      0, 'h2,      0);
    vecs[15] = mkv("wr_x9",            2'b01, 9,  0, 2'b01, 9, 'h33,     0, 0,         0, 0, 0, 'h33,     0, 'h2,      0);

    for (int k = 0; k < 16; k++) apply(vecs[k]);

    // Reset between clock edges clears outputs immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdata0", rdata[0], '0);
    check("async_rst_rdata1", rdata[1], '0);
    // Activity during reset must be ignored.
    @(negedge clk);
    drive(mkv("in_reset", 2'b11, 9, 9, 2'b01, 9, 'h44, 0, 0, 1, 9, 0,
              0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("in_reset_rdata0", rdata[0], '0);
    check("in_reset_rbusy", {30'b0, rbusy}, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(mkv("post_rst_x9", 2'b11, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_rst_x9_rdata0", rdata[0], '0);
    check("post_rst_x9_rdata1", rdata[1], '0);
    check("post_rst_x9_rbusy", {30'b0, rbusy}, '0);

    // Random traffic on a small address window to force collisions.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_m = '{default: '0};
    pend_m = '0;
    last_m.name = "";
    last_m.d = '0;
    last_m.b = '0;
    for (int c = 0; c < 400; c++) begin
      v.name = $sformatf("rand%0d", c);
      v.ren  = 2'($urandom_range(0, 3));
      v.wen  = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        v.ra[p] = AW'($urandom_range(0, 7));
        v.wa[p] = AW'($urandom_range(0, 7));
        v.wd[p] = $urandom();
      end
      v.al = ($urandom_range(0, 2) == 0);
      v.aa = AW'($urandom_range(0, 7));
      v.fl = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      drive(v);
      model_step(v, e);
      sb_q.push_back(e);
      cycle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp
